// File: rtl/varre_triang.sv
// varre_triang: scans the screen-clipped bounding box of one triangle in raster order, one pixel per beat
// Ports: clk, rst_n (async, active-low); in_valid/in_ready + p1x..p3y accept a triangle;
// out_valid/out_ready + ptx/pty, v1x..v3y, out_last emit pixels; busy is high in SETUP and SCAN.
module varre_triang #(
    parameter int W    = 11,
    parameter int XMAX = 639,
    parameter int YMAX = 479
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] p1x,
    input  logic [W-1:0] p1y,
    input  logic [W-1:0] p2x,
    input  logic [W-1:0] p2y,
    input  logic [W-1:0] p3x,
    input  logic [W-1:0] p3y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] ptx,
    output logic [W-1:0] pty,
    output logic [W-1:0] v1x,
    output logic [W-1:0] v1y,
    output logic [W-1:0] v2x,
    output logic [W-1:0] v2y,
    output logic [W-1:0] v3x,
    output logic [W-1:0] v3y,
    output logic         out_last,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;
    localparam logic [W-1:0] XM = W'(XMAX);
    localparam logic [W-1:0] YM = W'(YMAX);
    state_t state, state_nx;
    logic [W-1:0] xmin, xmax, ymin, ymax;
    logic [W-1:0] xmin_r, xmax_c, ymax_c;
    logic accept, xfer, offscreen;
    function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction
    function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
    assign xmin      = min3(v1x, v2x, v3x);
    assign xmax      = max3(v1x, v2x, v3x);
    assign ymin      = min3(v1y, v2y, v3y);
    assign ymax      = max3(v1y, v2y, v3y);
    assign offscreen = (xmin > XM) || (ymin > YM);
    // gating with rst_n keeps in_ready low for the whole time reset is held
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == SCAN);
    assign busy      = (state != IDLE);
    assign out_last  = out_valid && (ptx == xmax_c) && (pty == ymax_c);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    always_comb begin
        state_nx = state;
        if (state == IDLE && accept)
            state_nx = SETUP;
        else if (state == SETUP)
            state_nx = offscreen ? IDLE : SCAN;
        else if (state == SCAN && xfer && out_last)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1x, v1y, v2x, v2y, v3x, v3y} <= '0;
            ptx    <= '0;
            pty    <= '0;
            xmin_r <= '0;
            xmax_c <= '0;
            ymax_c <= '0;
        end else if (accept) begin
            {v1x, v1y, v2x, v2y, v3x, v3y} <= {p1x, p1y, p2x, p2y, p3x, p3y};
        end else if (state == SETUP) begin
            xmin_r <= xmin;
            xmax_c <= (xmax > XM) ? XM : xmax;
            ymax_c <= (ymax > YM) ? YM : ymax;
            if (!offscreen) begin
                ptx <= xmin;
                pty <= ymin;
            end
        end else if (xfer && !out_last) begin
            // end of a row wraps back to the left edge of the box
            ptx <= (ptx == xmax_c) ? xmin_r : ptx + 1'b1;
            pty <= (ptx == xmax_c) ? pty + 1'b1 : pty;
        end
    end
endmodule

// File: tb/tb_varre_triang.sv
// tb_varre_triang: directed table-driven bench for the triangle bounding-box scanner
module tb_varre_triang;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [10:0] p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0;
    logic in_ready, out_valid, out_last, busy;
    logic [10:0] ptx, pty, v1x, v1y, v2x, v2y, v3x, v3y;
    int compared = 0, mismatched = 0;
    typedef struct {
        int p1x, p1y, p2x, p2y, p3x, p3y;
        int x0, x1, y0, y1, n;
    } vec_t;
    vec_t vecs[8];
    varre_triang dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .out_valid(out_valid), .out_ready(out_ready), .ptx(ptx), .pty(pty),
        .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
        .out_last(out_last), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic start(input vec_t t);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("ready_before_accept", in_ready, 1);
        {p1x, p1y, p2x, p2y, p3x, p3y} = {11'(t.p1x), 11'(t.p1y), 11'(t.p2x), 11'(t.p2y), 11'(t.p3x), 11'(t.p3y)};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("setup_busy_valid_ready", {busy, out_valid, in_ready}, 3'b100);
        @(posedge clk);
        #1;
    endtask
    task automatic run(input vec_t t, input bit stall);
        int ex = t.x0, ey = t.y0, left = t.n, cyc = 0;
        bit rdy;
        bit [5:0] pat = 6'b101001;
        start(t);
        if (t.n == 0) begin
            chk("offscreen_valid_busy_ready", {out_valid, busy, in_ready}, 3'b001);
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("offscreen_quiet", out_valid, 0);
            end
            return;
        end
        while (left > 0 && cyc < 1000) begin
            rdy = stall ? pat[cyc % 6] : 1'b1;
            out_ready = rdy;
            chk("beat_valid_last_x_y", {out_valid, out_last, ptx, pty},
                {1'b1, (ex == t.x1 && ey == t.y1), 11'(ex), 11'(ey)});
            chk("verts", {v1x, v1y, v2x, v2y, v3x, v3y},
                {11'(t.p1x), 11'(t.p1y), 11'(t.p2x), 11'(t.p2y), 11'(t.p3x), 11'(t.p3y)});
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) begin
                left--;
                if (ex == t.x1) begin
                    ex = t.x0;
                    ey++;
                end else ex++;
            end
        end
        out_ready = 1'b0;
        chk("beats_left", 66'(left), 0);
        chk("after_last_valid_last_busy_ready", {out_valid, out_last, busy, in_ready}, 4'b0001);
    endtask
    initial begin
        vecs[0] = '{10, 10, 12, 10, 10, 11, 10, 12, 10, 11, 6};
        vecs[1] = '{20, 8, 18, 9, 19, 7, 18, 20, 7, 9, 9};
        vecs[2] = '{630, 470, 700, 470, 630, 500, 630, 639, 470, 479, 100};
        vecs[3] = '{700, 10, 800, 20, 750, 30, 0, 0, 0, 0, 0};
        vecs[4] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 1};
        vecs[5] = '{100, 200, 105, 200, 110, 200, 100, 110, 200, 200, 11};
        vecs[6] = '{639, 479, 2047, 2047, 639, 479, 639, 639, 479, 479, 1};
        vecs[7] = '{10, 480, 20, 490, 15, 500, 0, 0, 0, 0, 0};
        #1;
        chk("reset_ready_valid_last_busy", {in_ready, out_valid, out_last, busy}, 4'b0000);
        chk("reset_pt_verts", {ptx, pty, v1x, v3y}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_ready, 1);
        for (int i = 0; i < 8; i++) run(vecs[i], 1'b0);
        run(vecs[0], 1'b1);
        run(vecs[2], 1'b1);
        start(vecs[0]);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_pixel", {out_valid, ptx, pty}, {1'b1, 11'd10, 11'd11});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid_busy_ready_last", {out_valid, busy, in_ready, out_last}, 4'b0000);
        chk("async_reset_pt_v1x", {ptx, pty, v1x}, 0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(vecs[0], 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
